// File: rtl/hours_pkg.sv
// +----------------------------------------------------------------------------+
// | hours_pkg                                                                  |
// | Shared BCD digit type, segment patterns and the load range check.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package hours_pkg;

    typedef logic [3:0] bcd_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam bcd_t C_BCD_MAX = 4'd9;

    // A preset is legal when it does not exceed the wrap value
    function automatic logic load_in_range(
        input logic [1:0] tens,
        input bcd_t       units,
        input logic [1:0] wrap_tens,
        input bcd_t       wrap_units
    );
        return (tens <= wrap_tens) && (units <= C_BCD_MAX) &&
               !((tens == wrap_tens) && (units > wrap_units));
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_encode.sv
// +----------------------------------------------------------------------------+
// | seg7_encode                                                                |
// | Combinational BCD to active-low seven-segment decoder; non-BCD -> dash.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg7_encode
    import hours_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hours_down_counter.sv
// +----------------------------------------------------------------------------+
// | hours_down_counter                                                         |
// | Two-digit BCD 00..23 down counter with preset, borrow and 7-seg outputs.   |
// | Option macro: HOURS_DOWN_HOLD_AT_ZERO_EN (hold at 00 instead of wrapping). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hours_down_counter
    import hours_pkg::*;
#(
    parameter logic [1:0] WRAP_TENS   = 2'd2,
    parameter logic [3:0] WRAP_UNITS  = 4'd3,
    parameter logic [1:0] RESET_TENS  = 2'd0,
    parameter logic [3:0] RESET_UNITS = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [1:0] load_tens,
    input  logic [3:0] load_units,
    output logic [6:0] tens_seg,
    output logic [6:0] units_seg,
    output logic       borrow,
    output logic       zero,
    output logic       load_err
);

    logic [1:0] tens_q, tens_d;
    bcd_t       units_q, units_d;
    logic       borrow_q, borrow_d;
    logic       load_err_q, load_err_d;
    logic       zero_q, zero_d;
    logic [6:0] tens_seg_q, units_seg_q;
    logic [6:0] w_tens_seg, w_units_seg;
    logic       w_load_ok;

    assign w_load_ok = load_in_range(load_tens, load_units, WRAP_TENS, WRAP_UNITS);

    always_comb begin
        tens_d     = tens_q;
        units_d    = units_q;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (rst) begin
            tens_d  = RESET_TENS;
            units_d = RESET_UNITS;
        end else if (load) begin
            if (w_load_ok) begin
                tens_d  = load_tens;
                units_d = load_units;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            if (units_q != 4'd0) begin
                units_d = units_q - 4'd1;
            end else if (tens_q != 2'd0) begin
                tens_d  = tens_q - 2'd1;
                units_d = C_BCD_MAX;
            end else begin
`ifdef HOURS_DOWN_HOLD_AT_ZERO_EN
                tens_d  = 2'd0;
                units_d = 4'd0;
`else
                tens_d   = WRAP_TENS;
                units_d  = WRAP_UNITS;
                borrow_d = 1'b1;
`endif
            end
`ifdef HOURS_DOWN_HOLD_AT_ZERO_EN
            // Timer mode: terminal pulse on reaching 00, never while parked there
            if ((tens_q == 2'd0) && (units_q == 4'd1)) begin
                borrow_d = 1'b1;
            end
`endif
        end
    end

    assign zero_d = (tens_d == 2'd0) && (units_d == 4'd0);

    // Decode the next-state digits so the display lands with the count
    seg7_encode u_tens_enc (
        .digit_i ({2'b00, tens_d}),
        .seg_o   (w_tens_seg)
    );

    seg7_encode u_units_enc (
        .digit_i (units_d),
        .seg_o   (w_units_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q     <= RESET_TENS;
            units_q    <= RESET_UNITS;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            units_q    <= units_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
        zero_q      <= zero_d;
        tens_seg_q  <= w_tens_seg;
        units_seg_q <= w_units_seg;
    end

    assign tens_seg  = tens_seg_q;
    assign units_seg = units_seg_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign load_err  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hours_down_counter.sv
// +----------------------------------------------------------------------------+
// | tb_hours_down_counter                                                      |
// | Directed and random stimulus against an arithmetic hours model.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hours_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_tens = 2'd0;
    logic [3:0] load_units = 4'd0;
    logic [6:0] tens_seg, units_seg;
    logic       borrow, zero, load_err;

    int checks = 0;
    int failures = 0;

    int   m_count = 0;
    logic m_borrow = 1'b0;
    logic m_err = 1'b0;

    logic [6:0] seg_tab [10];

    hours_down_counter dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_tens  (load_tens),
        .load_units (load_units),
        .tens_seg   (tens_seg),
        .units_seg  (units_seg),
        .borrow     (borrow),
        .zero       (zero),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b count=%0d", tag, obs, exp, m_count);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the hours rules, compare
    task automatic step(input logic r, input logic t, input logic l,
                        input int lt, input int lu);
        @(negedge clk);
        rst = r; tick = t; load = l;
        load_tens = 2'(lt); load_units = 4'(lu);
        @(posedge clk);
        m_borrow = 1'b0;
        m_err    = 1'b0;
        if (r) begin
            m_count = 0;
        end else if (l) begin
            if (lt <= 2 && lu <= 9 && (lt * 10 + lu) <= 23) m_count = lt * 10 + lu;
            else m_err = 1'b1;
        end else if (t) begin
`ifdef HOURS_DOWN_HOLD_AT_ZERO_EN
            if (m_count == 1) m_borrow = 1'b1;
            if (m_count > 0) m_count = m_count - 1;
`else
            if (m_count == 0) begin
                m_count  = 23;
                m_borrow = 1'b1;
            end else begin
                m_count = m_count - 1;
            end
`endif
        end
        #1;
        check("tens_seg",  tens_seg,  seg_tab[m_count / 10]);
        check("units_seg", units_seg, seg_tab[m_count % 10]);
        check("zero",      {6'd0, zero},     {6'd0, m_count == 0});
        check("borrow",    {6'd0, borrow},   {6'd0, m_borrow});
        check("load_err",  {6'd0, load_err}, {6'd0, m_err});
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        // Reset, then tick below 00
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Tens borrow 20 -> 19
        step(0, 0, 1, 2, 0);
        step(0, 1, 0, 0, 0);
        // Rejected and accepted presets
        step(0, 0, 1, 2, 5);
        step(0, 0, 1, 3, 0);
        step(0, 0, 1, 1, 9);
        step(0, 0, 1, 0, 10);
        step(0, 0, 1, 2, 3);
        // Load beats tick; reset beats load
        step(0, 1, 1, 1, 2);
        step(1, 1, 1, 1, 5);
        // Timer-mode terminal sequence (wrap mode exercises 01->00->23)
        step(0, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        // Back-to-back ticks through a full cycle
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0);
        // Random mix
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
